// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : 16-entry direct-mapped BTB with 2-bit counters and a registered
//            mispredict/redirect; optional statistics under BP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 16;

  logic        r_valid  [ENTRIES];
  logic [25:0] r_tag    [ENTRIES];
  logic [31:0] r_target [ENTRIES];
  logic [1:0]  r_ctr    [ENTRIES];

  logic [3:0]  w_fidx;
  logic        w_fhit;
  logic [3:0]  w_ridx;
  logic        w_rhit;
  logic        w_mp_cond;
  logic        w_unused;

  // Byte-offset bits never participate in indexing or tagging.
  assign w_unused = ^{fetch_pc[1:0], res_pc[1:0]};

  assign w_fidx      = fetch_pc[5:2];
  assign w_fhit      = r_valid[w_fidx] && (r_tag[w_fidx] == fetch_pc[31:6]);
  assign pred_taken  = w_fhit && r_ctr[w_fidx][1];
  assign pred_target = pred_taken ? r_target[w_fidx] : 32'd0;

  assign w_ridx    = res_pc[5:2];
  assign w_rhit    = r_valid[w_ridx] && (r_tag[w_ridx] == res_pc[31:6]);
  assign w_mp_cond = res_valid &&
                     ((res_taken != res_pred_taken) ||
                      (res_taken && (res_target != res_pred_target)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b00;
      end
      mispredict  <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      mispredict <= w_mp_cond;
      // Redirect only moves when a flush is issued; it holds otherwise.
      if (w_mp_cond) begin
        redirect_pc <= res_taken ? res_target : (res_pc + 32'd4);
      end
      if (res_valid) begin
        if (w_rhit) begin
          if (res_taken) begin
            if (r_ctr[w_ridx] != 2'b11) r_ctr[w_ridx] <= r_ctr[w_ridx] + 2'b01;
          end else begin
            if (r_ctr[w_ridx] != 2'b00) r_ctr[w_ridx] <= r_ctr[w_ridx] - 2'b01;
          end
        end else if (res_taken) begin
          r_valid[w_ridx] <= 1'b1;
          r_ctr[w_ridx]   <= 2'b10;
        end
      end
    end
  end

  // Tag/target payload carries no reset; valid bits gate its use.
  always_ff @(posedge clk) begin
    if (!reset && res_valid && res_taken) begin
      r_target[w_ridx] <= res_target;
      if (!w_rhit) r_tag[w_ridx] <= res_pc[31:6];
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= 32'd0;
      r_stat_mispredicts <= 32'd0;
    end else begin
      if (res_valid) r_stat_branches    <= r_stat_branches + 32'd1;
      if (w_mp_cond) r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed scoreboard bench for branch_predictor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    int          row;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] redir;
    logic        chk_s;
    logic [31:0] sb;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   row_n = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected record per non-reset cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_taken",  e.row, {31'd0, pred_taken}, {31'd0, e.pt});
      chk("pred_target", e.row, pred_target, e.ptgt);
      chk("mispredict",  e.row, {31'd0, mispredict}, {31'd0, e.mp});
      chk("redirect_pc", e.row, redirect_pc, e.redir);
`ifdef BP_STATS_EN
      if (e.chk_s) begin
        chk("stat_branches",    e.row, stat_branches,    e.sb);
        chk("stat_mispredicts", e.row, stat_mispredicts, e.sm);
      end
`endif
    end
  end

  task automatic step_full(input logic rst, input logic [31:0] f,
                           input logic rv, input logic [31:0] rpc, input logic rtk,
                           input logic [31:0] rtgt, input logic rpt,
                           input logic [31:0] rptgt, input logic ept,
                           input logic [31:0] eptgt, input logic emp,
                           input logic [31:0] eredir, input logic cs,
                           input logic [31:0] esb, input logic [31:0] esm);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    fetch_pc        = f;
    res_valid       = rv;
    res_pc          = rpc;
    res_taken       = rtk;
    res_target      = rtgt;
    res_pred_taken  = rpt;
    res_pred_target = rptgt;
    if (!rst) begin
      row_n++;
      e.row = row_n; e.pt = ept; e.ptgt = eptgt; e.mp = emp; e.redir = eredir;
      e.chk_s = cs; e.sb = esb; e.sm = esm;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] f,
                      input logic rv, input logic [31:0] rpc, input logic rtk,
                      input logic [31:0] rtgt, input logic rpt,
                      input logic [31:0] rptgt, input logic ept,
                      input logic [31:0] eptgt, input logic emp,
                      input logic [31:0] eredir);
    step_full(rst, f, rv, rpc, rtk, rtgt, rpt, rptgt, ept, eptgt, emp, eredir,
              1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; fetch_pc = 32'h100; res_valid = 1'b0; res_pc = 32'd0;
    res_taken = 1'b0; res_target = 32'd0; res_pred_taken = 1'b0;
    res_pred_target = 32'd0;

    //   rst fetch        rv rpc          tk tgt      pt ptgt     | ept eptgt   emp eredir
    step(1, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0);
    step(1, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0);
    step_full(0, 32'h100, 0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0,
              1, 32'd0, 32'd0);
    // Allocate 0x100 -> 0x200, ctr 10.
    step(0, 32'h100,      1, 32'h100,     1, 32'h200, 0, 32'h0,    0, 32'h0,   0, 32'h0);
    step(0, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    1, 32'h200, 1, 32'h200);
    // Same-cycle fetch shows old ctr 10; ctr -> 01.
    step(0, 32'h100,      1, 32'h100,     0, 32'h0,   1, 32'h200,  1, 32'h200, 0, 32'h200);
    step(0, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   1, 32'h104);
    // ctr 01 -> 00, then saturates at 00; correct predictions, no flush.
    step(0, 32'h100,      1, 32'h100,     0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h104);
    step(0, 32'h100,      1, 32'h100,     0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h104);
    // Back-to-back taken resolves: 00 -> 01 -> 10, each flushes.
    step(0, 32'h100,      1, 32'h100,     1, 32'h200, 0, 32'h0,    0, 32'h0,   0, 32'h104);
    step(0, 32'h100,      1, 32'h100,     1, 32'h200, 0, 32'h0,    0, 32'h0,   1, 32'h200);
    // Wrong target: ctr 10 -> 11, target -> 0x250.
    step(0, 32'h100,      1, 32'h100,     1, 32'h250, 1, 32'h200,  1, 32'h200, 1, 32'h200);
    // Correct: ctr saturates at 11.
    step(0, 32'h100,      1, 32'h100,     1, 32'h250, 1, 32'h250,  1, 32'h250, 1, 32'h250);
    step(0, 32'h100,      1, 32'h100,     0, 32'h0,   1, 32'h250,  1, 32'h250, 0, 32'h250);
    step(0, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    1, 32'h250, 1, 32'h104);
    // Conflict at index 0: 0x140 evicts 0x100.
    step(0, 32'h140,      1, 32'h140,     1, 32'h300, 0, 32'h0,    0, 32'h0,   0, 32'h104);
    step(0, 32'h100,      0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   1, 32'h300);
    step(0, 32'h140,      0, 32'h0,       0, 32'h0,   0, 32'h0,    1, 32'h300, 0, 32'h300);
    // Wrapping not-taken redirect; miss not-taken leaves table untouched.
    step(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,  1, 32'h0,    0, 32'h0,   0, 32'h300);
    step(0, 32'hFFFFFFFC, 0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   1, 32'h0);
    step(0, 32'h100,      1, 32'h104,     0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0);
    step_full(0, 32'h104, 0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0,
              1, 32'd12, 32'd8);
    // Reset wins over a concurrent mispredicting resolve.
    step(1, 32'h140,      1, 32'h140,     1, 32'h300, 0, 32'h0,    0, 32'h0,   0, 32'h0);
    step_full(0, 32'h140, 0, 32'h0,       0, 32'h0,   0, 32'h0,    0, 32'h0,   0, 32'h0,
              1, 32'd0, 32'd0);
    step(0, 32'h140,      1, 32'h140,     1, 32'h300, 0, 32'h0,    0, 32'h0,   0, 32'h0);
    step_full(0, 32'h140, 0, 32'h0,       0, 32'h0,   0, 32'h0,    1, 32'h300, 1, 32'h300,
              1, 32'd1, 32'd1);
    step(0, 32'h140,      0, 32'h0,       0, 32'h0,   0, 32'h0,    1, 32'h300, 0, 32'h300);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
